// File: rtl/vip_pkg.sv
// Shared definitions for the video edge-processing path.
//   pk_state_e : frame tracking state (WAIT_FRAME / IN_FRAME)
//   WORD_W     : width of a packed pixel word
//   CNT_W      : width of the pixel/line geometry counters
//   sat_inc()  : saturating increment for the geometry counters
package vip_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 11;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    IN_FRAME   = 1'b1
  } pk_state_e;

  // Counters stick at all-ones instead of wrapping, so an overlong line or
  // frame can never alias back onto a legal count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/edge_detect_1b.sv
// Registered rise/fall detector for a single-bit level signal.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : level input
//   rise       : din high now, low on the previous clock (combinational)
//   fall       : din low now, high on the previous clock (combinational)
module edge_detect_1b (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic din_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_d <= 1'b0;
    end else begin
      din_d <= din;
    end
  end

  assign rise = din & ~din_d;
  assign fall = ~din & din_d;

endmodule

// File: rtl/edge_bit_packer.sv
// Packs the 1-bit Sobel edge stream into 16-bit words (bit15 = earliest
// pixel), flushes a zero-padded partial word at each line end, and checks
// line and frame geometry.
// Ports:
//   clk, rst_n   : pixel clock, asynchronous active-low reset
//   in_vsync     : frame sync, rising edge starts a new frame
//   in_href      : line valid; falling edge ends a line
//   in_clken     : pixel qualifier; a pixel is taken when in_href & in_clken
//   in_bit       : edge pixel
//   wr_en        : one-cycle write strobe, no backpressure
//   wr_data      : packed word, valid while wr_en is high
//   frame_start  : one-cycle pulse after a vsync rise
//   frame_done   : one-cycle pulse when line V_ACTIVE has ended
//   word_cnt     : words written in the current frame (wraps)
//   line_err     : sticky, a line's pixel count != H_ACTIVE (cleared per frame)
//   frame_err    : sticky, a frame was cut short by vsync (cleared by reset)
//   state_dbg    : current frame state, 1 = IN_FRAME
//
// Handshake: wr_en/wr_data is a valid-only stream. The consumer must take
// the word on every clock where wr_en is high; there is no ready signal and
// the packer never stalls. At most one word per clock is produced.
module edge_bit_packer
  import vip_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_vsync,
  input  logic        in_href,
  input  logic        in_clken,
  input  logic        in_bit,
  output logic        wr_en,
  output logic [15:0] wr_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic [15:0] word_cnt,
  output logic        line_err,
  output logic        frame_err,
  output logic        state_dbg
);

  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);

  pk_state_e state, state_next;

  logic [WORD_W-1:0] sreg, sreg_next;
  logic [3:0]        bit_cnt, bit_cnt_next;
  logic [CNT_W-1:0]  pix_cnt, pix_cnt_next;
  logic [CNT_W-1:0]  line_cnt, line_cnt_next;
  logic [CNT_W-1:0]  line_inc;

  logic              wr_en_next;
  logic [15:0]       wr_data_next;
  logic              frame_start_next;
  logic              frame_done_next;
  logic [15:0]       word_cnt_next;
  logic              line_err_next;
  logic              frame_err_next;

  logic vsync_rise, vsync_fall;
  logic href_rise, href_fall;
  logic accept;

  edge_detect_1b u_vsync_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (in_vsync),
    .rise (vsync_rise),
    .fall (vsync_fall)
  );

  edge_detect_1b u_href_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (in_href),
    .rise (href_rise),
    .fall (href_fall)
  );

  // vsync fall and href rise carry no meaning for packing.
  logic unused_edges;
  assign unused_edges = vsync_fall ^ href_rise;

  assign accept    = in_href & in_clken;
  assign line_inc  = sat_inc(line_cnt);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= WAIT_FRAME;
      sreg        <= '0;
      bit_cnt     <= '0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      wr_en       <= 1'b0;
      wr_data     <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      word_cnt    <= '0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_next;
      sreg        <= sreg_next;
      bit_cnt     <= bit_cnt_next;
      pix_cnt     <= pix_cnt_next;
      line_cnt    <= line_cnt_next;
      wr_en       <= wr_en_next;
      wr_data     <= wr_data_next;
      frame_start <= frame_start_next;
      frame_done  <= frame_done_next;
      word_cnt    <= word_cnt_next;
      line_err    <= line_err_next;
      frame_err   <= frame_err_next;
    end
  end

  always_comb begin
    state_next       = state;
    sreg_next        = sreg;
    bit_cnt_next     = bit_cnt;
    pix_cnt_next     = pix_cnt;
    line_cnt_next    = line_cnt;
    wr_en_next       = 1'b0;
    wr_data_next     = wr_data;
    frame_start_next = 1'b0;
    frame_done_next  = 1'b0;
    word_cnt_next    = word_cnt;
    line_err_next    = line_err;
    frame_err_next   = frame_err;

    if (vsync_rise) begin
      // A new frame overrides anything in flight. Inside a frame this means
      // the previous frame was short and any pending bits are dropped.
      if (state == IN_FRAME && (line_cnt != V_ACT_C || bit_cnt != 4'd0)) begin
        frame_err_next = 1'b1;
      end
      state_next       = IN_FRAME;
      frame_start_next = 1'b1;
      word_cnt_next    = '0;
      line_cnt_next    = '0;
      line_err_next    = 1'b0;
      pix_cnt_next     = '0;
      bit_cnt_next     = '0;
      sreg_next        = '0;
    end else if (state == IN_FRAME) begin
      if (accept) begin
        sreg_next    = {sreg[14:0], in_bit};
        bit_cnt_next = bit_cnt + 4'd1;
        pix_cnt_next = sat_inc(pix_cnt);
        if (bit_cnt == 4'd15) begin
          wr_en_next    = 1'b1;
          wr_data_next  = {sreg[14:0], in_bit};
          word_cnt_next = word_cnt + 16'd1;
        end
      end else if (href_fall) begin
        // Left-justify the leftover bits so bit15 stays the earliest pixel.
        if (bit_cnt != 4'd0) begin
          wr_en_next    = 1'b1;
          wr_data_next  = sreg << (5'd16 - {1'b0, bit_cnt});
          word_cnt_next = word_cnt + 16'd1;
          bit_cnt_next  = '0;
        end
        if (pix_cnt != H_ACT_C) begin
          line_err_next = 1'b1;
        end
        pix_cnt_next  = '0;
        line_cnt_next = line_inc;
        if (line_inc == V_ACT_C) begin
          frame_done_next = 1'b1;
          state_next      = WAIT_FRAME;
        end
      end
    end
  end

endmodule

// File: doc/edge_bit_packer.md
Name: edge_bit_packer

Overview:
Consumer of the binary edge stream produced by the Sobel stage: post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit.
- Packs 1-bit edge pixels into 16-bit words, MSB = earliest pixel, for the frame-buffer/Ethernet write path.
- Flushes a zero-padded partial word at line end.
- Emits frame boundary pulses and checks line/frame geometry against parameters.

Parameters:
H_ACTIVE, 640, expected pixels per line (accepted beats while href high); range 1..2047
V_ACTIVE, 480, expected lines per frame; range 1..2047

Ports:
clk  in  1  pixel clock, same domain as the Sobel stage
rst_n  in  1  asynchronous, active-low reset
in_vsync  in  1  frame sync, active high; rising edge = new frame
in_href  in  1  line valid, active high
in_clken  in  1  pixel qualifier; pixel accepted when in_href & in_clken
in_bit  in  1  edge pixel (1 = edge)
wr_en  out  1  one-cycle write strobe for wr_data
wr_data  out  16  packed pixels, bit15 = first pixel of the group
frame_start  out  1  one-cycle pulse on in_vsync rising edge
frame_done  out  1  one-cycle pulse when line V_ACTIVE completes (its href falling edge)
word_cnt  out  16  words written in the current frame; cleared on frame_start
line_err  out  1  sticky: some line's accepted count != H_ACTIVE; cleared on frame_start
frame_err  out  1  sticky: previous frame's line count != V_ACTIVE at next vsync rise; cleared by reset only

Behaviour:
- Reset: all outputs 0, shift register 0, bit count 0, line/pixel counters 0, state WAIT_FRAME.
- Edge detection: registered copies vsync_d, href_d. Rise = in & !d. Fall = !in & d.
- States:
  - WAIT_FRAME: all pixels ignored. On vsync rise: frame_start = 1 next cycle, go to IN_FRAME, clear word_cnt/line_cnt/line_err.
  - IN_FRAME: pack and count pixels.
  - A vsync rise in IN_FRAME:
    - frame_err set if line_cnt != V_ACTIVE.
    - Any partial word is discarded (no write); frame_err is also set.
    - Then treated as a new frame start; stays in IN_FRAME.
- Packing, on each accepted pixel in IN_FRAME:
  - sreg <= {sreg[14:0], in_bit}; bit_cnt (4 bits) increments; pix_cnt (11 bits) increments.
  - When the accepted pixel is the 16th (bit_cnt == 15): next cycle wr_en = 1, wr_data = {sreg[14:0], in_bit}, bit_cnt -> 0, word_cnt + 1.
  - Latency: one clock from the accepting edge to the wr_en cycle.
- Line end (href fall in IN_FRAME):
  - If bit_cnt != 0: next cycle wr_en = 1, wr_data = sreg << (16 - bit_cnt), zero-filled LSBs; bit_cnt -> 0; word_cnt + 1.
  - If bit_cnt == 0 (including a full word emitted on the previous edge): no flush.
  - line_err set if pix_cnt != H_ACTIVE. pix_cnt -> 0. line_cnt + 1.
  - If new line_cnt == V_ACTIVE: frame_done pulses the same cycle as the flush/update; state -> WAIT_FRAME.
  - If lines keep arriving after V_ACTIVE, they are ignored in WAIT_FRAME; no error.
- A full word and a flush can never coincide: the href fall is seen at least one cycle after the last accepted pixel.
- href rise: no action. href high with clken low: no accept.
- Counter widths:
  - word_cnt wraps at 2^16 with no error.
  - pix_cnt saturates at 2047; line_cnt saturates at 2047.
- Reset mid-frame: immediate async clear. Packing resumes only after the next vsync rise, never mid-frame.
- Throughput: one pixel per clock sustained. No backpressure; the downstream write port must accept a write every cycle wr_en is high.

Decomposition:
- Shared package (vip_pkg): state encoding WAIT_FRAME = 1'b0, IN_FRAME = 1'b1; WORD_W = 16; localparam CNT_W = 11.
- Optional sub-module edge_detect_1b (registered rise/fall detector), instanced for vsync and href. Everything else stays in the top module.

Test Plan:
All scenarios use H_ACTIVE = 20 and V_ACTIVE = 2.
- One vsync pulse, then 2 lines of 20 pixels, clken always 1, pattern 1010... -> per line: wr_en with 0xAAAA, then a flush of 0xA000; word_cnt = 4; frame_done once after line 2's href falls; line_err = 0, frame_err = 0.
- Same frame, but clken toggles 1/0 every cycle during href -> identical wr_data/word_cnt; wr_en spacing at least 2 cycles; no extra words.
- Line with exactly 16 pixels of 1 (line length differs from H_ACTIVE) -> single word 0xFFFF, no flush, line_err = 1; line_err cleared by the next vsync rise.
- Pixels driven before any vsync, then rst_n pulsed low mid-line -> no wr_en before the first vsync rise; all outputs 0 during reset; packing restarts at the next frame.
- Vsync rise after only 1 line, with 5 pixels pending in a dropped-href glitch -> frame_err = 1, no wr_en for the partial word, frame_start pulses, word_cnt = 0.
- 3 lines sent in one frame -> frame_done after line 2; line 3 produces no wr_en; frame_err stays 0.
